// File: rtl/key_debounce_repeat.sv
// Push-button front end: a 2-FF synchroniser and a debounce/auto-repeat FSM for each key.
// The auto-repeat path (REPEAT state, key_repeat, key_long) is built only when KEY_REPEAT_EN is defined.
module key_debounce_repeat #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_DEB_PRESS   = 3'd1;
    localparam logic [2:0] ST_HELD        = 3'd2;
`ifdef KEY_REPEAT_EN
    localparam logic [2:0] ST_REPEAT      = 3'd3;
`endif
    localparam logic [2:0] ST_DEB_RELEASE = 3'd4;

    // Per-key state is visible as gen_key[i].state_q for external checkers.
    for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_key
        logic [1:0]    sync_q;
        logic          k_s;
        logic [2:0]    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
`ifdef KEY_REPEAT_EN
        logic          repeat_q, repeat_d;
        logic          long_q, long_d;
`endif

        assign k_s = sync_q[1];

        // Reset value 0 means "released" in the inverted (1 = pressed) domain.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                sync_q <= 2'b00;
            end else begin
                sync_q <= {sync_q[0], ~KEY[g]};
            end
        end

        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
`ifdef KEY_REPEAT_EN
            repeat_d  = 1'b0;
            long_d    = long_q;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (k_s) begin
                        state_d = ST_DEB_PRESS;
                        cnt_d   = '0;
                    end
                end
                ST_DEB_PRESS: begin
                    if (!k_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                        press_d = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!k_s) begin
                        state_d = ST_DEB_RELEASE;
                        cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d  = ST_REPEAT;
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                        long_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
`endif
                    end
                end
`ifdef KEY_REPEAT_EN
                ST_REPEAT: begin
                    if (!k_s) begin
                        state_d = ST_DEB_RELEASE;
                        cnt_d   = '0;
                    end else if (cnt_q == REP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                ST_DEB_RELEASE: begin
                    // A short glitch returns to HELD: level stays up and hold timing restarts.
                    if (k_s) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
`ifdef KEY_REPEAT_EN
                        long_d  = 1'b0;
`endif
                    end else if (cnt_q == DEB_LAST) begin
                        state_d   = ST_IDLE;
                        cnt_d     = '0;
                        release_d = 1'b1;
                        level_d   = 1'b0;
`ifdef KEY_REPEAT_EN
                        long_d    = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
`ifdef KEY_REPEAT_EN
                    long_d  = 1'b0;
`endif
                end
            endcase
        end

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state_q   <= ST_IDLE;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
                repeat_q  <= 1'b0;
                long_q    <= 1'b0;
`endif
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
`ifdef KEY_REPEAT_EN
                repeat_q  <= repeat_d;
                long_q    <= long_d;
`endif
            end
        end

        assign key_level[g]   = level_q;
        assign key_press[g]   = press_q;
        assign key_release[g] = release_q;
`ifdef KEY_REPEAT_EN
        assign key_repeat[g]  = repeat_q;
        assign key_long[g]    = long_q;
`else
        assign key_repeat[g]  = 1'b0;
        assign key_long[g]    = 1'b0;
`endif
    end

endmodule
